// File: rtl/button_input_ctrl.sv
// button_input_ctrl: synchronise and debounce two push-buttons, generate press/auto-repeat
// step pulses and drive a wrap-around 5-bit up/down counter shown on the LEDs.
module button_input_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int REP_DELAY  = 12500000,
    parameter int REP_PERIOD = 2500000
) (
    input  logic       clk_25mhz,
    input  logic       reset,
    input  logic [1:0] btn,
    output logic [1:0] btn_level,
    output logic [1:0] btn_step,
    output logic [4:0] led
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int TW = $clog2(REP_DELAY > REP_PERIOD ? REP_DELAY : REP_PERIOD);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] DLY_MAX = TW'(REP_DELAY - 1);
    localparam logic [TW-1:0] PER_MAX = TW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    logic [1:0] s1, s2;

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            s1 <= 2'b00;
            s2 <= 2'b00;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic lvl, prev, step, step_nxt;
        logic [DW-1:0] cnt;
        logic [TW-1:0] timer, timer_nxt;
        state_t st, st_nxt;

        // any cycle of agreement restarts the stability window
        always_ff @(posedge clk_25mhz or posedge reset) begin
            if (reset) begin
                lvl <= 1'b0;
                cnt <= '0;
            end else if (s2[g] == lvl) begin
                cnt <= '0;
            end else if (cnt == DEB_MAX) begin
                lvl <= s2[g];
                cnt <= '0;
            end else begin
                cnt <= cnt + DW'(1);
            end
        end

        always_ff @(posedge clk_25mhz or posedge reset) begin
            if (reset) begin
                st    <= IDLE;
                timer <= '0;
                step  <= 1'b0;
                prev  <= 1'b0;
            end else begin
                st    <= st_nxt;
                timer <= timer_nxt;
                step  <= step_nxt;
                prev  <= lvl;
            end
        end

        always_comb begin
            st_nxt = st;
            case (st)
                IDLE:    st_nxt = (lvl && !prev) ? DELAY : IDLE;
                DELAY:   st_nxt = !lvl ? IDLE : (timer == DLY_MAX) ? REPEAT : DELAY;
                default: st_nxt = lvl ? REPEAT : IDLE;
            endcase
        end

        // release wins over a timer expiring in the same cycle
        always_comb begin
            step_nxt  = (st == IDLE) ? (lvl && !prev)
                                     : (lvl && timer == ((st == DELAY) ? DLY_MAX : PER_MAX));
            timer_nxt = (st == IDLE || !lvl || step_nxt) ? '0 : timer + TW'(1);
        end

        assign btn_level[g] = lvl;
        assign btn_step[g]  = step;
    end

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset)
            led <= 5'd0;
        else
            led <= (btn_step == 2'b01) ? led + 5'd1 :
                   (btn_step == 2'b10) ? led - 5'd1 : led;
    end
endmodule

// File: tb/tb_button_input_ctrl.sv
// tb_button_input_ctrl: scoreboard bench; expected step pulses (cycle, value) are queued
// as buttons are driven and matched against btn_step as it appears.
module tb_button_input_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] btn = 2'b00;
    logic [1:0] btn_level, btn_step;
    logic [4:0] led;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {int at; logic [1:0] val;} ev_t;
    ev_t exp_q[$];

    button_input_ctrl #(.DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(3)) dut (
        .clk_25mhz(clk),
        .reset(reset),
        .btn(btn),
        .btn_level(btn_level),
        .btn_step(btn_step),
        .led(led)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // consumer side of the scoreboard
    always @(negedge clk) begin
        if (btn_step !== 2'b00) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL step_unexpected: cycle %0d got %b, required no pulse", cyc, btn_step);
            end else begin
                if (exp_q[0].at != cyc || exp_q[0].val !== btn_step) begin
                    n_bad++;
                    $display("FAIL step_event: got cycle %0d step %b, required cycle %0d step %b",
                             cyc, btn_step, exp_q[0].at, exp_q[0].val);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int at, input logic [1:0] val);
        exp_q.push_back('{at: at, val: val});
    endtask

    task automatic do_reset;
        reset = 1'b1;
        btn = 2'b00;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_missing_steps: %0d pending, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    // press/hold/release of one button pattern, one pulse expected, led checked after
    task automatic press_once(input logic [1:0] b, input logic [4:0] led_exp, input string name);
        int c0;
        c0 = cyc;
        btn = b;
        push(c0 + 7, b);
        tick(9);
        btn = 2'b00;
        tick(14);
        n_cmp++;
        if (led !== led_exp) begin
            n_bad++;
            $display("FAIL %s_led: got %0d, required %0d", name, led, led_exp);
        end
    endtask

    task automatic test_reset;
        int c0, c1, s;
        reset = 1'b1;
        btn = 2'b00;
        tick(2);
        n_cmp++;
        if ({btn_level, btn_step, led} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_state: got lvl=%b step=%b led=%0d, required all 0", btn_level, btn_step, led);
        end
        reset = 1'b0;
        tick(1);
        c0 = cyc;
        s = c0 + 7;
        btn = 2'b01;
        push(s, 2'b01);
        for (int i = 10; i <= 25; i += 3) push(s + i, 2'b01);
        tick(33);
        n_cmp++;
        if (led !== 5'd7) begin
            n_bad++;
            $display("FAIL reset_pre_led: got %0d, required 7", led);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({btn_level, btn_step, led} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_async: got lvl=%b step=%b led=%0d, required all 0", btn_level, btn_step, led);
        end
        check_drained("reset_pre");
        tick(2);
        reset = 1'b0;
        c1 = cyc;
        push(c1 + 7, 2'b01);
        tick(5);
        n_cmp++;
        if (btn_level !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_redebounce_early: got lvl=%b, required 00", btn_level);
        end
        tick(1);
        n_cmp++;
        if (btn_level !== 2'b01) begin
            n_bad++;
            $display("FAIL reset_redebounce_level: got lvl=%b, required 01", btn_level);
        end
        tick(2);
        n_cmp++;
        if (led !== 5'd1) begin
            n_bad++;
            $display("FAIL reset_post_led: got %0d, required 1", led);
        end
        btn = 2'b00;
        tick(12);
        check_drained("reset_post");
    endtask

    task automatic test_glitch;
        int bad;
        do_reset();
        bad = 0;
        for (int r = 0; r < 28; r++) begin
            btn[0] = (r < 20) && (r % 4 != 3);
            @(negedge clk);
            if (btn_level !== 2'b00 || led !== 5'd0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL glitch_filter: %0d cycles with level/led set, required 0 (last lvl=%b led=%0d)",
                     bad, btn_level, led);
        end
        check_drained("glitch");
    endtask

    task automatic test_single;
        int c0;
        do_reset();
        c0 = cyc;
        btn = 2'b01;
        push(c0 + 7, 2'b01);
        tick(5);
        n_cmp++;
        if (btn_level !== 2'b00) begin
            n_bad++;
            $display("FAIL single_level_early: got %b, required 00", btn_level);
        end
        tick(1);
        n_cmp++;
        if (btn_level !== 2'b01) begin
            n_bad++;
            $display("FAIL single_level_rise: got %b, required 01", btn_level);
        end
        tick(3);
        btn = 2'b00;
        tick(5);
        n_cmp++;
        if (btn_level !== 2'b01) begin
            n_bad++;
            $display("FAIL single_level_hold: got %b, required 01", btn_level);
        end
        tick(1);
        n_cmp++;
        if (btn_level !== 2'b00) begin
            n_bad++;
            $display("FAIL single_level_fall: got %b, required 00", btn_level);
        end
        tick(14);
        n_cmp++;
        if (led !== 5'd1) begin
            n_bad++;
            $display("FAIL single_led: got %0d, required 1", led);
        end
        check_drained("single");
    endtask

    task automatic test_repeat;
        int c0, s;
        do_reset();
        c0 = cyc;
        s = c0 + 7;
        btn = 2'b01;
        push(s, 2'b01);
        for (int i = 10; i <= 19; i += 3) push(s + i, 2'b01);
        // release lands on the edge where the REPEAT timer would expire
        tick(22);
        btn = 2'b00;
        tick(14);
        n_cmp++;
        if (led !== 5'd5) begin
            n_bad++;
            $display("FAIL repeat_led: got %0d, required 5", led);
        end
        check_drained("repeat");
        press_once(2'b01, 5'd6, "repeat_rearm");
        check_drained("repeat_rearm");
    endtask

    task automatic test_wrap;
        do_reset();
        press_once(2'b10, 5'd31, "wrap_down");
        press_once(2'b01, 5'd0, "wrap_up0");
        press_once(2'b01, 5'd1, "wrap_up1");
        check_drained("wrap");
    endtask

    task automatic test_back_to_back;
        int c0, s, bad;
        do_reset();
        press_once(2'b01, 5'd1, "both_pre");
        c0 = cyc;
        s = c0 + 7;
        btn = 2'b11;
        push(s, 2'b11);
        push(s + 10, 2'b11);
        push(s + 13, 2'b11);
        bad = 0;
        for (int r = 0; r < 30; r++) begin
            if (r == 15) btn = 2'b00;
            @(negedge clk);
            if (led !== 5'd1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL both_led_hold: %0d cycles with led != 1 (last %0d), required 0", bad, led);
        end
        check_drained("both");
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_single();
        test_repeat();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
